reg_initiator: RTL and testbench
================================

# reg_initiator

Register-bus initiator that drives the `reg_if` master side toward a register-file node such as the PS control register block. It accepts single read or write commands on a valid/ready command port and performs one `reg_if` transaction per command. Write completions are qualified by `bvalid`, and read data is captured on `rvalid`. It returns one response per command. Firmware-side sequencers and DMA setup logic use it to program and poll registers without hand-driving `reg_if`.

## Interface
- `TIMEOUT_CYCLES`, default 256: number of wait cycles per transaction before an error response. Only used when `REG_INITIATOR_TIMEOUT_EN` is defined. Must be ≥ 2.
- `ADDR_WIDTH`: not a module parameter; taken from `reg_o.ADDR_WIDTH`.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`.
- `cmd_we`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  `ADDR_WIDTH`  register index.
- `cmd_wdata`  in  32  write data; ignored for reads.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed when `rsp_valid && rsp_ready`.
- `rsp_rdata`  out  32  read data; 0 for writes and on error.
- `rsp_err`  out  1  transaction timed out.
- `reg_o`  `reg_if.master`  drives `waddr`, `wdata`, `wvalid`, `raddr`, `arvalid`; samples `wready`, `aready`, `rvalid`, `rdata`, `bvalid`.

## Operation
- FSM states:
  - IDLE
  - WR_REQ
  - WR_RESP
  - RD_REQ
  - RESP
- IDLE:
  - `cmd_ready` = 1.
  - On accept, the command is latched. The FSM moves to WR_REQ if `cmd_we`, else to RD_REQ.
- WR_REQ:
  - Drives `wvalid` = 1, `waddr`/`wdata` = latched values.
  - On `wready` at the edge, moves to WR_RESP and drops `wvalid`.
- WR_RESP:
  - Waits for `bvalid` = 1, then moves to RESP with `rsp_rdata` = 0 and `rsp_err` = 0.
- RD_REQ:
  - Drives `arvalid` = 1, `raddr` = latched address.
  - On `aready && rvalid` at the edge, captures `rdata` into `rsp_rdata` and moves to RESP.
- RESP:
  - Holds `rsp_valid` = 1 with stable data until `rsp_ready`, then returns to IDLE.
- Exactly one outstanding transaction at a time. `cmd_ready` is 0 outside IDLE.
- `bvalid`/`rvalid` are ignored outside WR_RESP/RD_REQ (no stray completion is counted).
- `wvalid` and `arvalid` are never high simultaneously.
- Reset mid-transaction: on the next edge the FSM goes to IDLE, all bus valids drop, and any pending response is discarded.

## Timing
- All outputs are registered except `cmd_ready`, which is decoded from the state.
- Reset values:
  - `cmd_ready` = 1 after reset (IDLE).
  - `rsp_valid`, `rsp_err`, `wvalid`, `arvalid` = 0.
  - `rsp_rdata`, `waddr`, `wdata`, `raddr` = 0.
- Write, with the slave holding `wready` = 1 and asserting `bvalid` one cycle after `wvalid`. The command is accepted at edge E0, then:
  - `wvalid` high in cycle E0+1.
  - `bvalid` high in cycle E0+2.
  - `rsp_valid` high from cycle E0+3.
- Read, with the slave giving `aready` = 1 and combinational `rvalid`. The command is accepted at edge E0, then:
  - `arvalid` high in cycle E0+1.
  - `rsp_valid` high from cycle E0+2.
- Next command accept: earliest in the cycle after `rsp_valid && rsp_ready`. No back-to-back overlap.
- Back-pressure: `wvalid`/`arvalid` and their address/data are held stable while `wready`/`aready`/`rvalid` are low.

## Configuration
- `REG_INITIATOR_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to WR_REQ/RD_REQ and increments every cycle in WR_REQ, WR_RESP and RD_REQ.
  - When it equals `TIMEOUT_CYCLES - 1` without completion, `wvalid`/`arvalid` are dropped and the FSM moves to RESP with `rsp_err` = 1 and `rsp_rdata` = 0.
  - A completion in that same cycle takes priority over the timeout.
- Not defined:
  - No counter; the FSM waits indefinitely.
  - `rsp_err` is tied to 0.

## Test plan
- Write addr 1, data 0x0000_00A5, with an `rf_node`-style slave -> `wvalid` for one cycle, `rsp_valid` 3 cycles after accept, `rsp_err` = 0, `rsp_rdata` = 0.
- Read back addr 1 after that write -> `rsp_rdata` = 0x0000_00A5 two cycles after accept.
- Hold `rsp_ready` = 0 for 5 cycles -> `rsp_valid`/`rsp_rdata` stable and `cmd_ready` = 0 throughout; accept resumes the cycle after `rsp_ready`.
- With the timeout macro defined, `TIMEOUT_CYCLES` = 8, and `bvalid` never asserted -> `rsp_err` = 1 at cycle E0+9 and `wvalid` low. Without the macro, the FSM is still in WR_RESP after 100 cycles.
- Assert `rst` for 1 cycle while in RD_REQ -> `arvalid` = 0 and `cmd_ready` = 1 on the next cycle; no `rsp_valid` for that read.
- Pulse `bvalid` while IDLE, then issue a read -> no spurious response; exactly one response, with the read data.

Source files
------------

// File: rtl/reg_initiator_if.sv
// reg_if: simple register bus between an initiator (master) and a register-file node (slave).
// Write channel: waddr/wdata/wvalid/wready with a bvalid completion; read channel: raddr/arvalid/aready with rvalid/rdata.
interface reg_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] waddr;
  logic [31:0]           wdata;
  logic                  wvalid;
  logic                  wready;
  logic                  bvalid;
  logic [ADDR_WIDTH-1:0] raddr;
  logic                  arvalid;
  logic                  aready;
  logic                  rvalid;
  logic [31:0]           rdata;

  modport master (
    output waddr, wdata, wvalid, raddr, arvalid,
    input  wready, aready, rvalid, rdata, bvalid
  );

  modport slave (
    input  waddr, wdata, wvalid, raddr, arvalid,
    output wready, aready, rvalid, rdata, bvalid
  );
endinterface

// File: rtl/reg_initiator.sv
// reg_initiator: turns valid/ready read/write commands into single reg_if transactions, one response each.
// Optional per-transaction timeout enabled by defining REG_INITIATOR_TIMEOUT_EN.
module reg_initiator #(
  parameter int TIMEOUT_CYCLES = 256
) (
  reg_if.master                       reg_o,
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_we,
  input  logic [reg_o.ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]                 cmd_wdata,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [31:0]                 rsp_rdata,
  output logic                        rsp_err
);
  localparam int ADDR_WIDTH = reg_o.ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RESP
  } state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   waddr_reg, waddr_next;
  logic [31:0]             wdata_reg, wdata_next;
  logic                    wvalid_reg, wvalid_next;
  logic [ADDR_WIDTH-1:0]   raddr_reg, raddr_next;
  logic                    arvalid_reg, arvalid_next;
  logic                    rsp_valid_reg, rsp_valid_next;
  logic [31:0]             rsp_rdata_reg, rsp_rdata_next;
  logic                    rsp_err_reg, rsp_err_next;
  logic                    timeout;

`ifdef REG_INITIATOR_TIMEOUT_EN
  logic [15:0] cnt_reg, cnt_next;

  // >= rather than == so a wait that straddles WR_REQ -> WR_RESP at the limit still expires.
  assign timeout = (cnt_reg >= 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_next     = state_reg;
    waddr_next     = waddr_reg;
    wdata_next     = wdata_reg;
    wvalid_next    = wvalid_reg;
    raddr_next     = raddr_reg;
    arvalid_next   = arvalid_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_err_next   = rsp_err_reg;
`ifdef REG_INITIATOR_TIMEOUT_EN
    cnt_next       = cnt_reg + 16'd1;
`endif

    case (state_reg)
      IDLE: begin
`ifdef REG_INITIATOR_TIMEOUT_EN
        cnt_next = '0;
`endif
        if (cmd_valid) begin
          if (cmd_we) begin
            waddr_next  = cmd_addr;
            wdata_next  = cmd_wdata;
            wvalid_next = 1'b1;
            state_next  = WR_REQ;
          end else begin
            raddr_next   = cmd_addr;
            arvalid_next = 1'b1;
            state_next   = RD_REQ;
          end
        end
      end

      WR_REQ: begin
        if (reg_o.wready) begin
          wvalid_next = 1'b0;
          state_next  = WR_RESP;
        end else if (timeout) begin
          wvalid_next    = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_rdata_next = '0;
          rsp_err_next   = 1'b1;
          state_next     = RESP;
        end
      end

      WR_RESP: begin
        if (reg_o.bvalid) begin
          rsp_valid_next = 1'b1;
          rsp_rdata_next = '0;
          rsp_err_next   = 1'b0;
          state_next     = RESP;
        end else if (timeout) begin
          rsp_valid_next = 1'b1;
          rsp_rdata_next = '0;
          rsp_err_next   = 1'b1;
          state_next     = RESP;
        end
      end

      RD_REQ: begin
        // Completion wins over a timeout expiring in the same cycle.
        if (reg_o.aready && reg_o.rvalid) begin
          arvalid_next   = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_rdata_next = reg_o.rdata;
          rsp_err_next   = 1'b0;
          state_next     = RESP;
        end else if (timeout) begin
          arvalid_next   = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_rdata_next = '0;
          rsp_err_next   = 1'b1;
          state_next     = RESP;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end

      default: begin
        wvalid_next    = 1'b0;
        arvalid_next   = 1'b0;
        rsp_valid_next = 1'b0;
        state_next     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      waddr_reg     <= '0;
      wdata_reg     <= '0;
      wvalid_reg    <= 1'b0;
      raddr_reg     <= '0;
      arvalid_reg   <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      waddr_reg     <= waddr_next;
      wdata_reg     <= wdata_next;
      wvalid_reg    <= wvalid_next;
      raddr_reg     <= raddr_next;
      arvalid_reg   <= arvalid_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_err_reg   <= rsp_err_next;
    end
  end

  assign cmd_ready     = (state_reg == IDLE);
  assign rsp_valid     = rsp_valid_reg;
  assign rsp_rdata     = rsp_rdata_reg;
  assign rsp_err       = rsp_err_reg;
  assign reg_o.waddr   = waddr_reg;
  assign reg_o.wdata   = wdata_reg;
  assign reg_o.wvalid  = wvalid_reg;
  assign reg_o.raddr   = raddr_reg;
  assign reg_o.arvalid = arvalid_reg;
endmodule

// File: tb/tb_reg_initiator.sv
// Self-checking bench for reg_initiator: register-file slave model, directed vector table,
// multi-cycle corner sequences and randomized traffic checked against a flat register-array model.
module tb_reg_initiator;
  localparam int AW = 4;
  localparam int TO = 8;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   exp_rdata;
    int            exp_lat;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_we = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [31:0]   cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;

  reg_if #(.ADDR_WIDTH(AW)) bus ();

  reg_initiator #(.TIMEOUT_CYCLES(TO)) dut (
    .reg_o     (bus),
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  // ---------------- register-file slave ----------------
  logic [31:0] slv_mem [16];
  logic        mem_clear = 1'b1;
  logic        bvalid_en = 1'b1;
  logic        bvalid_force = 1'b0;
  logic        bvalid_q = 1'b0;
  logic        rand_bp = 1'b0;
  logic        block_aready = 1'b0;
  logic        wready_en = 1'b1;
  logic        aready_en = 1'b1;
  logic        rvalid_en = 1'b1;

  assign bus.wready = wready_en;
  assign bus.aready = aready_en;
  assign bus.rvalid = bus.arvalid && rvalid_en;
  assign bus.rdata  = slv_mem[bus.raddr];
  assign bus.bvalid = bvalid_q || bvalid_force;

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 16; i++) slv_mem[i] <= '0;
    end else if (bus.wvalid && bus.wready) begin
      slv_mem[bus.waddr] <= bus.wdata;
    end
    bvalid_q  <= rst ? 1'b0 : (bvalid_en && bus.wvalid && bus.wready);
    wready_en <= rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
    aready_en <= block_aready ? 1'b0 : (rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1);
    rvalid_en <= rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // ---------------- bus protocol monitor ----------------
  int            wv_count = 0;
  int            overlap_cnt = 0;
  int            unstable_cnt = 0;
  int            rsp_count = 0;
  logic          p_wv = 1'b0, p_wr = 1'b0, p_av = 1'b0, p_ok = 1'b0, p_rst = 1'b1;
  logic [AW-1:0] p_wa = '0, p_ra = '0;
  logic [31:0]   p_wd = '0;

  always @(negedge clk) begin
    if (bus.wvalid) wv_count <= wv_count + 1;
    if (bus.wvalid && bus.arvalid) overlap_cnt <= overlap_cnt + 1;
    if (rsp_valid && rsp_ready) rsp_count <= rsp_count + 1;
    if (!p_rst && !rst && rand_bp &&
        ((p_wv && !p_wr && (!bus.wvalid || bus.waddr != p_wa || bus.wdata != p_wd)) ||
         (p_av && !p_ok && (!bus.arvalid || bus.raddr != p_ra))))
      unstable_cnt <= unstable_cnt + 1;
    p_wv  <= bus.wvalid;
    p_wr  <= bus.wready;
    p_wa  <= bus.waddr;
    p_wd  <= bus.wdata;
    p_av  <= bus.arvalid;
    p_ok  <= bus.aready && bus.rvalid;
    p_ra  <= bus.raddr;
    p_rst <= rst;
  end

  // ---------------- checking helpers ----------------
  int checks = 0;
  int failures = 0;
  logic [31:0] model [16];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic we, input logic [AW-1:0] addr, input logic [31:0] wdata,
                        input int hold, output logic [31:0] rdata, output logic err,
                        output int lat, output int wv);
    int waits;
    int wv0;
    waits = 0;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    while (!cmd_ready && waits < 50) begin
      tick();
      waits++;
    end
    check("cmd_ready_wait", cmd_ready, 1'b1);
    wv0 = wv_count;
    tick();
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 300) begin
      tick();
      lat++;
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    for (int h = 0; h < hold; h++) begin
      check("hold_stable", {rsp_valid, cmd_ready, rsp_rdata}, {1'b1, 1'b0, rdata});
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    wv = wv_count - wv0;
    check("accept_resume", {cmd_ready, rsp_valid}, 2'b10);
    $display("txn we=%0d addr=%0d wdata=%08h rdata=%08h err=%0d lat=%0d", we, addr, wdata, rdata, err, lat);
  endtask

  vec_t vecs [9];

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          wv;
    int          seen;
    int          rc0;
    logic [31:0] exp;
    logic        we;
    logic [AW-1:0] a;
    logic [31:0] d;

    for (int i = 0; i < 16; i++) model[i] = '0;
    vecs[0] = '{1'b1, 4'd1,  32'h0000_00A5, 32'h0, 3};
    vecs[1] = '{1'b0, 4'd1,  32'h0,         32'h0000_00A5, 2};
    vecs[2] = '{1'b1, 4'd15, 32'hFFFF_FFFF, 32'h0, 3};
    vecs[3] = '{1'b0, 4'd15, 32'h0,         32'hFFFF_FFFF, 2};
    vecs[4] = '{1'b1, 4'd0,  32'h1234_5678, 32'h0, 3};
    vecs[5] = '{1'b0, 4'd0,  32'h0,         32'h1234_5678, 2};
    vecs[6] = '{1'b0, 4'd7,  32'h0,         32'h0, 2};
    vecs[7] = '{1'b1, 4'd1,  32'hDEAD_BEEF, 32'h0, 3};
    vecs[8] = '{1'b0, 4'd1,  32'h0,         32'hDEAD_BEEF, 2};

    repeat (3) tick();
    rst = 1'b0;
    mem_clear = 1'b0;
    tick();

    // reset state
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, '0);
    check("rst_valids", {bus.wvalid, bus.arvalid}, 2'b00);
    check("rst_addr_data", {bus.waddr, bus.wdata, bus.raddr}, '0);

    // directed vectors with an always-ready slave
    foreach (vecs[i]) begin
      do_cmd(vecs[i].we, vecs[i].addr, vecs[i].wdata, 0, rd, er, lat, wv);
      if (vecs[i].we) model[vecs[i].addr] = vecs[i].wdata;
      check("vec_rdata", rd, vecs[i].exp_rdata);
      check("vec_err", er, 1'b0);
      check("vec_latency", lat, vecs[i].exp_lat);
      check("vec_wvalid_cycles", wv, vecs[i].we ? 1 : 0);
    end

    // response held off for 5 cycles
    do_cmd(1'b1, 4'd3, 32'hCAFE_0003, 5, rd, er, lat, wv);
    model[3] = 32'hCAFE_0003;
    check("hold_wr_rdata", rd, 32'h0);
    do_cmd(1'b0, 4'd3, 32'h0, 5, rd, er, lat, wv);
    check("hold_rd_rdata", rd, 32'hCAFE_0003);

    // write whose completion never arrives
    bvalid_en = 1'b0;
    model[2] = 32'h0000_0055;
`ifdef REG_INITIATOR_TIMEOUT_EN
    do_cmd(1'b1, 4'd2, 32'h0000_0055, 0, rd, er, lat, wv);
    check("timeout_latency", lat, TO + 1);
    check("timeout_err", er, 1'b1);
    check("timeout_rdata", rd, 32'h0);
    check("timeout_wvalid", bus.wvalid, 1'b0);
`else
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 4'd2; cmd_wdata = 32'h0000_0055;
    tick();
    cmd_valid = 1'b0;
    seen = 0;
    repeat (100) begin
      tick();
      if (rsp_valid || cmd_ready) seen++;
    end
    check("no_timeout_stuck", seen, 0);
    check("no_timeout_wvalid", bus.wvalid, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("stuck_reset_ready", cmd_ready, 1'b1);
`endif
    bvalid_en = 1'b1;
    tick();

    // reset while a read waits in RD_REQ
    block_aready = 1'b1;
    tick();
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 4'd1;
    tick();
    cmd_valid = 1'b0;
    check("rd_req_arvalid", bus.arvalid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_arvalid", bus.arvalid, 1'b0);
    check("rst_mid_cmd_ready", cmd_ready, 1'b1);
    block_aready = 1'b0;
    seen = 0;
    repeat (6) begin
      tick();
      if (rsp_valid) seen++;
    end
    check("rst_mid_no_rsp", seen, 0);

    // stray bvalid while idle, then a read
    bvalid_force = 1'b1;
    tick();
    bvalid_force = 1'b0;
    tick();
    check("stray_idle", {rsp_valid, cmd_ready}, 2'b01);
    rc0 = rsp_count;
    do_cmd(1'b0, 4'd1, 32'h0, 0, rd, er, lat, wv);
    check("stray_read_data", rd, model[1]);
    repeat (4) tick();
    check("stray_rsp_count", rsp_count - rc0, 1);

    // randomized traffic with bus back-pressure
`ifndef REG_INITIATOR_TIMEOUT_EN
    rand_bp = 1'b1;
`endif
    for (int n = 0; n < 150; n++) begin
      we = 1'($urandom_range(0, 1));
      a  = AW'($urandom_range(0, 15));
      d  = $urandom;
      exp = we ? 32'h0 : model[a];
      do_cmd(we, a, d, $urandom_range(0, 2), rd, er, lat, wv);
      if (we) model[a] = d;
      check("rand_rdata", rd, exp);
      check("rand_err", er, 1'b0);
    end
    rand_bp = 1'b0;
    repeat (3) tick();

    check("no_wvalid_arvalid_overlap", overlap_cnt, 0);
    check("backpressure_stable", unstable_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=expired expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
